// File: rtl/cfb_sched_pkg.sv
// Shared types for the CFB stream scheduler: FSM states and result FIFO entry.
package cfb_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    // Result FIFO depth; issue gating below relies on this being small and fixed.
    localparam int FIFO_DEPTH = 2;

    // Widest requester id a FIFO entry can carry; the top truncates to its own ID_W.
    localparam int FIFO_ID_W = 8;

    typedef struct packed {
        logic [FIFO_ID_W-1:0] id;
        logic                 last;
        logic [7:0]           data;
    } fifo_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the highest-priority index,
// which moves to the slot just after the winner when the grant is accepted.
module rr_arbiter #(
    parameter int  N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_req
);
    // ptr_reg is the requester with the highest priority (last grant + 1).
    logic [ID_W-1:0] ptr_reg;
    logic            found;

    assign any_req = |req;

    // Rotating first-set search starting at the priority pointer.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!found && req[(int'(ptr_reg) + off) % N_REQ]) begin
                found = 1'b1;
                grant[(int'(ptr_reg) + off) % N_REQ] = 1'b1;
                grant_id = ID_W'((int'(ptr_reg) + off) % N_REQ);
            end
        end
    end

    // Advance priority past the winner only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (accept && found) begin
            ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/cfb_stream_scheduler.sv
// Time-shares one byte-wide CFB cipher core among N_REQ requesters: picks a
// descriptor round-robin, loads the core key, streams the bytes through and
// queues tagged results in a 2-entry FIFO with backpressure.
module cfb_stream_scheduler
    import cfb_sched_pkg::*;
#(
    parameter int  N_REQ = 2,
    parameter int  LEN_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [8*N_REQ-1:0]     req_key,
    input  logic [N_REQ-1:0]       req_enc_dec,
    input  logic [LEN_W*N_REQ-1:0] req_len,
    input  logic [N_REQ-1:0]       s_valid,
    input  logic [8*N_REQ-1:0]     s_data,
    output logic [N_REQ-1:0]       s_ready,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [7:0]             m_data,
    output logic [ID_W-1:0]        m_id,
    output logic                   m_last,
    output logic                   core_new_msg,
    output logic                   core_enc_dec,
    output logic                   core_in_valid,
    output logic [7:0]             core_key,
    output logic [7:0]             core_in_msg,
    input  logic                   core_out_ready,
    input  logic [7:0]             core_out_msg,
    output logic                   busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t             state_reg, state_next;
    logic [7:0]         key_reg;
    logic               enc_dec_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [ID_W-1:0]    id_reg;
    logic               inflight_reg;
    logic               inflight_last_reg;

    fifo_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    fifo_entry_t        head, push_entry;

    logic [7:0]         key_arr  [N_REQ];
    logic [LEN_W-1:0]   len_arr  [N_REQ];
    logic [7:0]         data_arr [N_REQ];

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               any_req, accept;
    logic               issue_ok, issue, push, pop;
    logic [CNT_W:0]     occupancy;

    // Slice the flat per-requester buses into arrays.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign key_arr[gi]  = req_key[8*gi +: 8];
            assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
            assign data_arr[gi] = s_data[8*gi +: 8];
            assign s_ready[gi]  = (state_reg == STREAM) && issue_ok &&
                                  (remaining_reg != '0) && (id_reg == ID_W'(gi));
        end
    endgenerate

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .accept   (accept),
        .grant    (grant),
        .grant_id (grant_id),
        .any_req  (any_req)
    );

    assign req_ready = accept ? grant : '0;

    // A byte may enter the core only if the FIFO can still absorb it counting
    // the byte already inside the core and the pop happening this cycle.
    always_comb begin
        occupancy = (CNT_W+1)'(count_reg) + (CNT_W+1)'(inflight_reg) - (CNT_W+1)'(pop);
        issue_ok  = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    end

    assign issue         = s_valid[id_reg] & s_ready[id_reg];
    assign push          = core_out_ready & inflight_reg;
    assign pop           = m_valid & m_ready;

    assign core_new_msg  = (state_reg == LOAD);
    assign core_in_valid = issue;
    assign core_in_msg   = (state_reg == STREAM) ? data_arr[id_reg] : 8'h00;
    assign core_key      = key_reg;
    assign core_enc_dec  = enc_dec_reg;
    assign busy          = (state_reg != IDLE) || (count_reg != '0);

    // Next-state logic; DRAIN waits out the final core result so a stale done
    // strobe can never land after the next key load.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    accept     = 1'b1;
                    state_next = (len_arr[grant_id] == '0) ? IDLE : LOAD;
                end
            end
            LOAD:    state_next = STREAM;
            STREAM:  if (issue && remaining_reg == LEN_W'(1)) state_next = DRAIN;
            DRAIN:   if (!inflight_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Descriptor latch, byte countdown and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg           <= '0;
            enc_dec_reg       <= 1'b0;
            remaining_reg     <= '0;
            id_reg            <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            if (accept) begin
                key_reg       <= key_arr[grant_id];
                enc_dec_reg   <= req_enc_dec[grant_id];
                remaining_reg <= len_arr[grant_id];
                id_reg        <= grant_id;
            end
            if (issue) begin
                remaining_reg     <= remaining_reg - LEN_W'(1);
                inflight_reg      <= 1'b1;
                inflight_last_reg <= (remaining_reg == LEN_W'(1));
            end else if (push) begin
                inflight_reg      <= 1'b0;
            end
        end
    end

    // Result being captured carries the tag of the byte that produced it.
    always_comb begin
        push_entry      = '0;
        push_entry.id   = FIFO_ID_W'(id_reg);
        push_entry.last = inflight_last_reg;
        push_entry.data = core_out_msg;
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head    = fifo_mem[rd_ptr_reg];
    assign m_valid = (count_reg != '0);
    assign m_data  = m_valid ? head.data : 8'h00;
    assign m_id    = m_valid ? ID_W'(head.id) : '0;
    assign m_last  = m_valid & head.last;

endmodule

// File: tb/tb_cfb_stream_scheduler.sv
// Bench for cfb_stream_scheduler with a behavioural AES-S-box CFB core model.
module tb_cfb_stream_scheduler;
    localparam int N_REQ = 2;
    localparam int LEN_W = 8;
    localparam int ID_W  = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N_REQ-1:0]       req_valid, req_ready, req_enc_dec, s_valid, s_ready;
    logic [8*N_REQ-1:0]     req_key, s_data;
    logic [LEN_W*N_REQ-1:0] req_len;
    logic                   m_valid, m_ready, m_last;
    logic [7:0]             m_data;
    logic [ID_W-1:0]        m_id;
    logic                   core_new_msg, core_enc_dec, core_in_valid, core_out_ready;
    logic [7:0]             core_key, core_in_msg;
    logic [7:0]             core_out_msg = 8'h00;
    logic                   busy;

    always #5 clk = ~clk;

    cfb_stream_scheduler #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .req_enc_dec(req_enc_dec), .req_len(req_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last),
        .core_new_msg(core_new_msg), .core_enc_dec(core_enc_dec), .core_in_valid(core_in_valid),
        .core_key(core_key), .core_in_msg(core_in_msg),
        .core_out_ready(core_out_ready), .core_out_msg(core_out_msg), .busy(busy)
    );

    // ---------------- core model: AES S-box CFB, 1-cycle latency ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic       model_ready = 1'b0;
    logic       spur_ready  = 1'b0;
    logic [7:0] fb_reg      = 8'h00;
    logic       cenc_reg    = 1'b0;
    assign core_out_ready = model_ready | spur_ready;

    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (core_new_msg) begin
            fb_reg   <= core_key;
            cenc_reg <= core_enc_dec;
        end else if (core_in_valid) begin
            core_out_msg <= core_in_msg ^ sbox(fb_reg);
            model_ready  <= 1'b1;
            fb_reg       <= cenc_reg ? (core_in_msg ^ sbox(fb_reg)) : core_in_msg;
        end
    end

    // ---------------- monitor ----------------
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int got_data[$];
    int got_id[$];
    int got_last[$];
    int got_cyc[$];
    int grants[$];
    int grant_cyc[$];
    int new_cnt = 0, in_cnt = 0, mv_cnt = 0, overlap_cnt = 0;
    int last_oready_cyc = -1;
    int min_gap = 1000;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_data.push_back(int'(m_data));
            got_id.push_back(int'(m_id));
            got_last.push_back(int'(m_last));
            got_cyc.push_back(cycle);
            $display("xfer cyc=%0d id=%0d data=%02h last=%0b", cycle, m_id, m_data, m_last);
        end
        if (|req_ready) begin
            grants.push_back(req_ready[1] ? 1 : 0);
            grant_cyc.push_back(cycle);
            $display("grant cyc=%0d req_ready=%b", cycle, req_ready);
        end
        if (core_new_msg) begin
            new_cnt++;
            if (last_oready_cyc >= 0 && (cycle - last_oready_cyc) < min_gap)
                min_gap = cycle - last_oready_cyc;
        end
        if (core_in_valid) in_cnt++;
        if (core_new_msg && core_in_valid) overlap_cnt++;
        if (model_ready) last_oready_cyc = cycle;
        if (m_valid) mv_cnt++;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_request(input int id, input logic [7:0] key, input logic enc,
                              input logic [7:0] len, output logic ok);
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_key[8*id +: 8] = key;
        req_enc_dec[id] = enc;
        req_len[LEN_W*id +: LEN_W] = len;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic do_stream(input int id, input logic [31:0] din, input int len, output logic ok);
        logic got;
        ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            got = 1'b0;
            s_valid[id] = 1'b1;
            s_data[8*id +: 8] = din[8*i +: 8];
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if (s_ready[id]) got = 1'b1;
            end
            @(posedge clk); #1;
            if (!got) ok = 1'b0;
        end
        s_valid[id] = 1'b0;
    endtask

    task automatic wait_out(input int target, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (got_data.size() >= target) ok = 1'b1;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [7:0]  id;
        logic [7:0]  key;
        logic        enc;
        logic [7:0]  len;
        logic [31:0] din;   // byte i at bits [8i+7:8i]
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok, ok_a, ok_b, ok_c, ok_d, ok_e, ok_f, ok_g, ok_h;
        int base, gbase, nm, iv, mv, in_base;
        logic [31:0] exp_bp;

        vecs[0] = '{id: 8'd0, key: 8'h00, enc: 1'b1, len: 8'd2, din: 32'h0000_0000, dout: 32'h0000_FB63};
        vecs[1] = '{id: 8'd1, key: 8'h00, enc: 1'b0, len: 8'd2, din: 32'h0000_FB63, dout: 32'h0000_0000};
        vecs[2] = '{id: 8'd0, key: 8'h00, enc: 1'b1, len: 8'd4, din: 32'h0000_0000, dout: 32'h760F_FB63};
        vecs[3] = '{id: 8'd1, key: 8'h01, enc: 1'b1, len: 8'd1, din: 32'h0000_0012, dout: 32'h0000_006E};
        vecs[4] = '{id: 8'd0, key: 8'h53, enc: 1'b0, len: 8'd1, din: 32'h0000_00ED, dout: 32'h0000_0000};
        vecs[5] = '{id: 8'd1, key: 8'h10, enc: 1'b1, len: 8'd2, din: 32'h0000_00FF, dout: 32'h0000_9635};

        req_valid = '0; req_key = '0; req_enc_dec = '0; req_len = '0;
        s_valid = '0; s_data = '0; m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_core_new_msg", core_new_msg, 0);
        check("reset_s_ready", s_ready, 0);
        rst = 1'b1;

        // Table-driven messages
        for (int v = 0; v < 6; v++) begin
            base  = got_data.size();
            gbase = grant_cyc.size();
            do_request(int'(vecs[v].id), vecs[v].key, vecs[v].enc, vecs[v].len, ok);
            check($sformatf("v%0d_req_ready", v), ok, 1);
            do_stream(int'(vecs[v].id), vecs[v].din, int'(vecs[v].len), ok);
            check($sformatf("v%0d_s_ready", v), ok, 1);
            wait_out(base + int'(vecs[v].len), ok);
            check($sformatf("v%0d_out_count", v), ok, 1);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                if (got_data.size() > base + i) begin
                    check($sformatf("v%0d_data%0d", v, i), got_data[base+i], {24'h0, vecs[v].dout[8*i +: 8]});
                    check($sformatf("v%0d_id%0d", v, i), got_id[base+i], {24'h0, vecs[v].id});
                    check($sformatf("v%0d_last%0d", v, i), got_last[base+i],
                          (i == int'(vecs[v].len) - 1) ? 1 : 0);
                end
            end
            if (v == 0 && got_cyc.size() > base && grant_cyc.size() > gbase)
                check("latency_req_to_m_valid", got_cyc[base] - grant_cyc[gbase], 4);
            if (v == 2 && got_cyc.size() > base + 3)
                check("throughput_4_bytes", got_cyc[base+3] - got_cyc[base], 3);
        end

        // Contention: both requesters want two single-byte messages
        gbase = grants.size();
        base  = got_data.size();
        fork
            begin
                do_request(0, 8'h00, 1'b1, 8'd1, ok_a); do_stream(0, 32'h0, 1, ok_b);
                do_request(0, 8'h00, 1'b1, 8'd1, ok_c); do_stream(0, 32'h0, 1, ok_d);
            end
            begin
                do_request(1, 8'h00, 1'b1, 8'd1, ok_e); do_stream(1, 32'h0, 1, ok_f);
                do_request(1, 8'h00, 1'b1, 8'd1, ok_g); do_stream(1, 32'h0, 1, ok_h);
            end
        join
        wait_out(base + 4, ok);
        check("cont_out_count", ok, 1);
        check("cont_handshakes", {ok_a, ok_b, ok_c, ok_d, ok_e, ok_f, ok_g, ok_h}, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            if (grants.size() > gbase + i)
                check($sformatf("cont_grant%0d", i), grants[gbase+i], i % 2);
            if (got_data.size() > base + i) begin
                check($sformatf("cont_id%0d", i), got_id[base+i], i % 2);
                check($sformatf("cont_data%0d", i), got_data[base+i], 32'h63);
            end
        end
        check("no_load_issue_overlap", overlap_cnt, 0);
        check("gap_out_ready_to_load_ge2", (min_gap >= 2) ? 1 : 0, 1);

        // Backpressure: len=4 with consumer stalled
        m_ready = 1'b0;
        base    = got_data.size();
        in_base = in_cnt;
        fork
            begin
                do_request(0, 8'h00, 1'b1, 8'd4, ok_a);
                do_stream(0, 32'h0, 4, ok_b);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_bytes_issued", in_cnt - in_base, 2);
                check("bp_s_ready_low", s_ready, 0);
                check("bp_m_valid", m_valid, 1);
                check("bp_nothing_delivered", got_data.size() - base, 0);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_out(base + 4, ok);
        check("bp_out_count", ok & ok_a & ok_b, 1);
        exp_bp = 32'h760F_FB63;
        for (int i = 0; i < 4; i++) begin
            if (got_data.size() > base + i) begin
                check($sformatf("bp_data%0d", i), got_data[base+i], {24'h0, exp_bp[8*i +: 8]});
                check($sformatf("bp_last%0d", i), got_last[base+i], (i == 3) ? 1 : 0);
            end
        end

        // Zero-length descriptor
        nm = new_cnt; iv = in_cnt; mv = mv_cnt;
        do_request(1, 8'hAA, 1'b1, 8'd0, ok);
        check("len0_req_ready", ok, 1);
        repeat (8) @(negedge clk);
        check("len0_no_load", new_cnt - nm, 0);
        check("len0_no_issue", in_cnt - iv, 0);
        check("len0_no_m_valid", mv_cnt - mv, 0);
        check("len0_idle", busy, 0);

        // Spurious core result while idle
        mv = mv_cnt;
        @(posedge clk); #1; spur_ready = 1'b1;
        @(posedge clk); #1; spur_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("spur_no_m_valid", mv_cnt - mv, 0);
        check("spur_idle", busy, 0);

        // Async reset mid-STREAM with one FIFO entry held
        do_request(0, 8'h5A, 1'b1, 8'd4, ok);
        check("rst_seq_req_ready", ok, 1);
        do_stream(0, 32'h0, 1, ok);
        m_ready = 1'b0;
        check("rst_seq_first_byte", ok, 1);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_valid) ok = 1'b1;
        end
        check("rst_pre_m_valid", ok, 1);
        check("rst_pre_core_key", core_key, 32'h5A);
        #2;
        rst = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_s_ready", s_ready, 0);
        check("arst_core_key", core_key, 0);
        check("arst_core_enc_dec", core_enc_dec, 0);
        check("arst_m_data", m_data, 0);
        check("arst_core_in_valid", core_in_valid, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        m_ready = 1'b1;

        // After reset requester 0 has priority again
        base = got_data.size();
        @(posedge clk); #1;
        req_valid = 2'b11;
        req_key = {8'h00, 8'h01};
        req_enc_dec = 2'b11;
        req_len = {8'd1, 8'd1};
        @(negedge clk);
        check("post_rst_grant", req_ready, 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        do_stream(0, 32'h12, 1, ok);
        check("post_rst_stream", ok, 1);
        wait_out(base + 1, ok);
        check("post_rst_out", ok, 1);
        if (got_data.size() > base) begin
            check("post_rst_data", got_data[base], 32'h6E);
            check("post_rst_id", got_id[base], 0);
        end
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
